// File: rtl/seq_match_if.sv
// Config/command and symbol-stream bundle for the configurable sequence detector.
interface seq_match_if #(
  parameter int MAXLEN = 4,
  parameter int CNT_W  = 8
);
  logic                  cfg_we;
  logic [2*MAXLEN-1:0]   cfg_pat;
  logic [2:0]            cfg_len;
  logic [CNT_W-1:0]      cfg_target;
  logic                  start;
  logic                  in_valid;
  logic [1:0]            num;
  logic                  match;
  logic                  busy;
  logic                  done;
  logic [CNT_W-1:0]      match_cnt;

  modport master (
    output cfg_we, cfg_pat, cfg_len, cfg_target, start, in_valid, num,
    input  match, busy, done, match_cnt
  );

  modport slave (
    input  cfg_we, cfg_pat, cfg_len, cfg_target, start, in_valid, num,
    output match, busy, done, match_cnt
  );
endinterface

// File: rtl/seq_match_ctrl.sv
// Run controller for a programmable 1..MAXLEN symbol detector: arms on start,
// counts non-overlapping matches and stops after a programmed match count.
module seq_match_ctrl #(
  parameter int MAXLEN = 4,
  parameter int CNT_W  = 8
) (
  input  logic       clk,
  input  logic       reset,
  seq_match_if.slave bus
);
  localparam int PW = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;
  localparam logic [2*MAXLEN-1:0] PAT_RST = {{(2*MAXLEN-6){1'b0}}, 6'b11_10_01};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_q;
  logic [PW-1:0]       prog_q;
  logic [2*MAXLEN-1:0] pat_q;
  logic [2:0]          len_q;
  logic [CNT_W-1:0]    tgt_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                match_q, busy_q, done_q;

  logic [1:0]       cur_sym;
  logic             hit, last, restart;
  logic [CNT_W-1:0] cnt_inc;
  logic [2:0]       len_in;

  assign cur_sym = pat_q[2*int'(prog_q) +: 2];
  assign hit     = (bus.num == cur_sym);
  assign last    = (int'(prog_q) == int'(len_q) - 1);
  assign restart = (bus.num == pat_q[1:0]);
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  // Out-of-range lengths collapse to the full pattern width.
  assign len_in  = (bus.cfg_len == 3'd0 || int'(bus.cfg_len) > MAXLEN)
                   ? 3'(MAXLEN) : bus.cfg_len;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      prog_q  <= '0;
      pat_q   <= PAT_RST;
      len_q   <= 3'd3;
      tgt_q   <= '0;
      cnt_q   <= '0;
      match_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      match_q <= 1'b0;
      if (bus.cfg_we && state_q != RUN) begin
        pat_q <= bus.cfg_pat;
        len_q <= len_in;
        tgt_q <= bus.cfg_target;
      end
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            state_q <= RUN;
            prog_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        RUN: begin
          if (bus.in_valid) begin
            if (hit && last) begin
              prog_q  <= '0;
              match_q <= 1'b1;
              cnt_q   <= cnt_inc;
              if (tgt_q != '0 && cnt_inc == tgt_q) begin
                state_q <= DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end else if (hit) begin
              prog_q <= prog_q + 1'b1;
            end else begin
              // A failed symbol may itself begin a fresh attempt.
              prog_q <= restart ? PW'(1) : '0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.match     = match_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.match_cnt = cnt_q;
endmodule

// File: doc/seq_match_ctrl.md
Name: seq_match_ctrl

Overview:
- Run controller for the 2-bit symbol sequence detector: holds a programmable pattern of 1-4 symbols and match length.
- Arms and disarms detection on command, counts matches, and signals completion after a programmed number of matches.
- Sits between the control/config interface and the 2-bit symbol stream (`num`), replacing the fixed 1-2-3 detector wherever the pattern or run length must be configurable.

Parameters:
- MAXLEN, 4: maximum pattern length in symbols. The pattern bus is 2*MAXLEN bits.
- CNT_W, 8: width of the match counter and target.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- cfg_we  input  1  load cfg_pat/cfg_len/cfg_target this cycle. Accepted only in IDLE or DONE.
- cfg_pat  input  2*MAXLEN  pattern; symbol k in bits [2k+1:2k], symbol 0 matched first.
- cfg_len  input  3  pattern length 1..MAXLEN; 0 or >MAXLEN is stored as MAXLEN.
- cfg_target  input  CNT_W  matches required for done; 0 = run forever.
- start  input  1  arm a run. Accepted only in IDLE or DONE.
- in_valid  input  1  num carries a symbol this cycle.
- num  input  2  input symbol.
- match  output  1  one-cycle pulse: a full pattern completed on the previous accepted symbol.
- busy  output  1  high in RUN.
- done  output  1  high in DONE.
- match_cnt  output  CNT_W  matches counted in the current/last run; saturates at all-ones.

Behaviour:
- Reset (synchronous, highest priority):
  - state=IDLE; progress pointer=0; match=0; busy=0; done=0; match_cnt=0.
  - Config defaults: pat = {.., 2'b11, 2'b10, 2'b01} (sequence 1,2,3; unused upper symbols 0), len=3, target=0.
  - Reset mid-run aborts the run with no match pulse.
- Run-state FSM (IDLE, RUN, DONE):
  - IDLE -> RUN on start. progress=0 and match_cnt=0 on the same edge.
  - RUN -> DONE on the edge where a match brings match_cnt to cfg_target (target != 0).
  - DONE -> RUN on start, clearing as above. No other exit from DONE except reset.
  - start in RUN is ignored.
- Config:
  - cfg_we in IDLE/DONE loads all three config registers on that edge.
  - cfg_we in RUN is ignored; registers are unchanged.
  - cfg_we and start asserted in the same cycle: both take effect on that edge; the run uses the new config from the next cycle.
- Matching, in RUN, for each cycle with in_valid=1 (progress p, 0..len-1):
  - num == pat[p] and p == len-1: progress <- 0; match <- 1 next cycle; match_cnt increments (saturating).
  - num == pat[p] and p < len-1: progress <- p+1.
  - Mismatch: progress <- (num == pat[0]) ? 1 : 0. With len==1, a mismatch against pat[0] always gives 0.
- Matches do not overlap: after a match, the next symbol is compared against pat[0].
- in_valid=0: progress holds; match=0.
- In IDLE and DONE, symbols are ignored, progress holds at 0, and match=0.
- Latency: match rises exactly 1 cycle after the edge that samples the completing symbol, high for 1 cycle. Back-to-back matches (len=1) give consecutive pulses.
- busy and done are registered, decoded from state, and never high together.
- match_cnt holds its value in DONE and IDLE until the next start or reset.
- Counter at all-ones with target=0: stays at all-ones; matching continues.

Test Plan:
- Reset, start, feed 1,2,3 with in_valid=1 -> match pulse 1 cycle after the "3" edge; match_cnt=1; busy=1.
- Default config, feed 1,2,1,2,3,0,1,2,2,3 -> exactly one match (after the 5th symbol); match_cnt=1. Confirms restart-on-pat[0] and 2-then-2 reset to 0.
- cfg_pat=8'b00000010, cfg_len=1, cfg_target=3, start, feed 2,2,0,2,2 -> match on the 1st, 2nd and 4th symbols; done rises with the 3rd match; busy falls; 5th symbol ignored; match_cnt=3.
- During RUN: pulse cfg_we with len=2 and start -> config and progress unchanged. Feed 1,0,2,0,3 with in_valid low on the 0 cycles -> match after the 3.
- Mid-pattern (after 1,2): assert reset -> all outputs 0, config back to 1,2,3/len 3. Then start and feed 3 -> no match.
- cfg_we together with start in DONE -> new pattern used from the next cycle; match_cnt cleared to 0.
